// File: rtl/layer_sequencer_pkg.sv
// Shared types and Q2.13 fixed-point helpers for the layer sequencer.
package layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam int FRAC_BITS = 13;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  localparam logic signed [16:0] SUM_MAX = 17'sd32767;
  localparam logic signed [16:0] SUM_MIN = -17'sd32768;

  // Clamp a 17-bit signed sum into Q2.13, optionally folding negatives to zero.
  function automatic logic [15:0] sat_relu(input logic signed [16:0] sum, input logic relu);
    logic [15:0] r;
    if (sum > SUM_MAX) r = Q_MAX;
    else if (sum < SUM_MIN) r = Q_MIN;
    else r = sum[15:0];
    if (relu && r[15]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/q_bias_act.sv
// Combinational bias add with Q2.13 saturation and optional ReLU.
module q_bias_act
  import layer_sequencer_pkg::*;
#(
  parameter int RELU = 1
) (
  input  logic [15:0] z,
  input  logic [15:0] bias,
  output logic [15:0] y
);

  logic signed [16:0] sum;

  always_comb begin
    sum = $signed({z[15], z}) + $signed({bias[15], bias});
    y   = sat_relu(sum, RELU != 0);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Runs one dense layer through an external MAC neuron: per output it clears,
// streams X/W, drains the pipeline, then writes the biased, activated result.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 20,
  parameter int MAC_LAT = 3,
  parameter int RELU    = 1,
  localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            Busy,
  output logic            Done,
  output logic [XA_W-1:0] X_Addr,
  input  logic [15:0]     X_Data,
  output logic [WA_W-1:0] W_Addr,
  input  logic [15:0]     W_Data,
  output logic [BA_W-1:0] B_Addr,
  input  logic [15:0]     B_Data,
  output logic            Active,
  output logic [15:0]     X,
  output logic [15:0]     W,
  input  logic [15:0]     Z_In,
  output logic [BA_W-1:0] Y_Addr,
  output logic [15:0]     Y_Data,
  output logic            Y_We
);

  localparam int D_W = (MAC_LAT + 2 > 1) ? $clog2(MAC_LAT + 2) : 1;
  localparam logic [XA_W-1:0] X_LAST = XA_W'(N_IN - 1);
  localparam logic [D_W-1:0]  D_LAST = D_W'(MAC_LAT + 1);
  localparam logic [BA_W-1:0] J_LAST = BA_W'(N_OUT - 1);
  localparam logic [XA_W-1:0] X_ONE  = XA_W'(1);
  localparam logic [WA_W-1:0] W_ONE  = WA_W'(1);
  localparam logic [D_W-1:0]  D_ONE  = D_W'(1);
  localparam logic [BA_W-1:0] J_ONE  = BA_W'(1);

  state_t state, state_nxt;

  logic [XA_W-1:0] x_addr;
  logic [WA_W-1:0] w_addr;
  logic [BA_W-1:0] b_addr, y_addr, j;
  logic [D_W-1:0]  drain_cnt;
  logic            issue_q;
  logic            stream_last, drain_last, j_last;
  logic [15:0]     act_y;

  assign stream_last = (x_addr == X_LAST);
  assign drain_last  = (drain_cnt == D_LAST);
  assign j_last      = (j == J_LAST);

  assign X_Addr = x_addr;
  assign W_Addr = w_addr;
  assign B_Addr = b_addr;
  assign Y_Addr = y_addr;

  q_bias_act #(.RELU(RELU)) u_bias_act (
    .z    (Z_In),
    .bias (B_Data),
    .y    (act_y)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (Start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (stream_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_last) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = j_last ? S_FINISH : S_CLEAR;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operands are gated by the delayed issue flag so the neuron sees zeros
  // whenever the memories are not returning a streamed element.
  always_comb begin
    Busy   = (state inside {S_CLEAR, S_STREAM, S_DRAIN, S_WRITE});
    Done   = (state == S_FINISH);
    Active = (state inside {S_STREAM, S_DRAIN, S_WRITE});
    Y_We   = (state == S_WRITE);
    X      = issue_q ? X_Data : 16'h0000;
    W      = issue_q ? W_Data : 16'h0000;
    Y_Data = (state == S_WRITE) ? act_y : 16'h0000;
  end

  // The weight address runs on across outputs; it steps into the next row on
  // entering STREAM so it can hold the last issued address while idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      y_addr    <= '0;
      j         <= '0;
      drain_cnt <= '0;
      issue_q   <= 1'b0;
    end else begin
      issue_q <= (state == S_STREAM);
      case (state)
        S_IDLE: begin
          if (Start) begin
            j      <= '0;
            w_addr <= '0;
          end
        end
        S_CLEAR: begin
          x_addr <= '0;
          if (j != '0) w_addr <= w_addr + W_ONE;
        end
        S_STREAM: begin
          if (!stream_last) begin
            x_addr <= x_addr + X_ONE;
            w_addr <= w_addr + W_ONE;
          end else begin
            b_addr    <= j;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + D_ONE;
          if (drain_last) y_addr <= j;
        end
        S_WRITE: begin
          if (!j_last) j <= j + J_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (ReLU on/off) share stimulus, each
// driving a behavioural memory and MAC neuron; results go through a scoreboard.
module tb_layer_sequencer;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 2;
  localparam int MAC_LAT = 3;
  localparam int XA_W    = $clog2(N_IN);
  localparam int WA_W    = $clog2(N_IN * N_OUT);
  localparam int BA_W    = $clog2(N_OUT);
  localparam int EW      = 16 + BA_W;

  logic Clk, Reset, Start;
  logic            busy [2], done [2], active [2], y_we [2];
  logic [XA_W-1:0] xa [2];
  logic [WA_W-1:0] wa [2];
  logic [BA_W-1:0] ba [2], ya [2];
  logic [15:0]     xd [2], wd [2], bd [2], xo [2], wo [2], z [2], yd [2];

  logic [15:0] xmem [N_IN];
  logic [15:0] wmem [N_IN*N_OUT];
  logic [15:0] bmem [N_OUT];

  int total, bad;
  int ywe_cnt [2], done_cnt [2];
  logic [EW-1:0]   exp_q0[$], exp_q1[$];
  logic [WA_W-1:0] w_trace[$];
  logic [XA_W-1:0] x_trace[$];
  int run_len, low_run;
  bit prev_active;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT), .RELU(1)) u_relu (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(busy[0]), .Done(done[0]),
    .X_Addr(xa[0]), .X_Data(xd[0]), .W_Addr(wa[0]), .W_Data(wd[0]),
    .B_Addr(ba[0]), .B_Data(bd[0]), .Active(active[0]), .X(xo[0]), .W(wo[0]),
    .Z_In(z[0]), .Y_Addr(ya[0]), .Y_Data(yd[0]), .Y_We(y_we[0])
  );

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT), .RELU(0)) u_lin (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(busy[1]), .Done(done[1]),
    .X_Addr(xa[1]), .X_Data(xd[1]), .W_Addr(wa[1]), .W_Data(wd[1]),
    .B_Addr(ba[1]), .B_Data(bd[1]), .Active(active[1]), .X(xo[1]), .W(wo[1]),
    .Z_In(z[1]), .Y_Addr(ya[1]), .Y_Data(yd[1]), .Y_We(y_we[1])
  );

  // Memories with one-cycle read latency, and a neuron with a MAC_LAT-deep
  // product pipeline, an accumulator cleared by Active=0, and a Z register.
  logic signed [31:0] pipe [2][MAC_LAT];
  logic signed [31:0] acc [2];

  always @(posedge Clk) begin
    logic signed [15:0] xs, ws;
    logic signed [31:0] p;
    for (int k = 0; k < 2; k++) begin
      xd[k] <= xmem[xa[k]];
      wd[k] <= wmem[wa[k]];
      bd[k] <= bmem[ba[k]];
      xs = xo[k];
      ws = wo[k];
      p  = xs * ws;
      pipe[k][0] <= p >>> 13;
      for (int s = 1; s < MAC_LAT; s++) pipe[k][s] <= pipe[k][s-1];
      acc[k] <= active[k] ? acc[k] + pipe[k][MAC_LAT-1] : 32'sd0;
      z[k]   <= acc[k][15:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_y(input int j, input bit relu);
    logic signed [31:0] sum, p;
    logic signed [15:0] xs, ws, zs, bs;
    logic signed [16:0] s;
    logic [15:0] r;
    sum = 0;
    for (int i = 0; i < N_IN; i++) begin
      xs  = xmem[i];
      ws  = wmem[j*N_IN + i];
      p   = xs * ws;
      sum = sum + (p >>> 13);
    end
    zs = sum[15:0];
    bs = bmem[j];
    s  = zs + bs;
    if (s > 17'sd32767) r = 16'h7FFF;
    else if (s < -17'sd32768) r = 16'h8000;
    else r = s[15:0];
    if (relu && r[15]) r = 16'h0000;
    return r;
  endfunction

  // Scoreboard and address-trace monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) done_cnt[k]++;
      if (y_we[k] === 1'b1) ywe_cnt[k]++;
    end
    if (y_we[0] === 1'b1) begin
      check("y_expected_relu", exp_q0.size() > 0, 1'b1);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("y_relu", {ya[0], yd[0]}, e);
      end
    end
    if (y_we[1] === 1'b1) begin
      check("y_expected_lin", exp_q1.size() > 0, 1'b1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("y_lin", {ya[1], yd[1]}, e);
      end
    end
    if (active[0] === 1'b1) begin
      if (!prev_active) check("active_low_run", low_run, 1);
      if (run_len < N_IN) begin
        w_trace.push_back(wa[0]);
        x_trace.push_back(xa[0]);
      end
      run_len++;
      low_run = 0;
    end else begin
      run_len = 0;
      if (busy[0] === 1'b1) low_run++;
    end
    prev_active = (active[0] === 1'b1);
  end

  task automatic load(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < N_IN; i++) xmem[i] = x;
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = w;
    for (int i = 0; i < N_OUT; i++) bmem[i] = b;
  endtask

  task automatic load_random();
    for (int i = 0; i < N_IN; i++) xmem[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < N_OUT; i++) bmem[i] = 16'($urandom_range(0, 65535));
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_ctl"}, {busy[k], done[k], active[k], y_we[k]}, 0);
      check({tag, "_xwy"}, {xo[k], wo[k], yd[k]}, 0);
      check({tag, "_addr"}, {xa[k], wa[k], ba[k], ya[k]}, 0);
    end
  endtask

  task automatic run_pass(input string tag, input bit poke);
    int cyc, y0, y1, d0, d1;
    y0 = ywe_cnt[0]; y1 = ywe_cnt[1];
    d0 = done_cnt[0]; d1 = done_cnt[1];
    w_trace.delete();
    x_trace.delete();
    for (int j = 0; j < N_OUT; j++) begin
      exp_q0.push_back({BA_W'(j), exp_y(j, 1'b1)});
      exp_q1.push_back({BA_W'(j), exp_y(j, 1'b0)});
    end
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, busy[0], 1'b1);
    while (done[0] !== 1'b1 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (poke) Start = (cyc == 8);
    end
    check({tag, "_latency"}, cyc, 23);
    check({tag, "_busy_at_done"}, busy[0], 1'b0);
    if (poke) begin
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check({tag, "_restart_ignored"}, busy[0], 1'b0);
    end
    repeat (12) @(negedge Clk);
    check({tag, "_ywe_relu"}, ywe_cnt[0] - y0, N_OUT);
    check({tag, "_ywe_lin"}, ywe_cnt[1] - y1, N_OUT);
    check({tag, "_done_relu"}, done_cnt[0] - d0, 1);
    check({tag, "_done_lin"}, done_cnt[1] - d1, 1);
    check({tag, "_queue_left"}, exp_q0.size() + exp_q1.size(), 0);
    check({tag, "_trace_len"}, w_trace.size(), N_IN*N_OUT);
    for (int i = 0; i < w_trace.size() && i < N_IN*N_OUT; i++) begin
      check({tag, "_w_addr_trace"}, w_trace[i], i);
      check({tag, "_x_addr_trace"}, x_trace[i], i % N_IN);
    end
  endtask

  task automatic reset_mid_pass();
    int y0, y1, d0;
    y0 = ywe_cnt[0]; y1 = ywe_cnt[1]; d0 = done_cnt[0];
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("mid_active", active[0], 1'b1);
    check("mid_x_addr", xa[0], 1);
    check("mid_x", xo[0], 16'h2000);
    #2 Reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge Clk); Reset = 1'b0;
    repeat (30) @(negedge Clk);
    check("mid_no_write", (ywe_cnt[0] - y0) + (ywe_cnt[1] - y1), 0);
    check("mid_no_done", done_cnt[0] - d0, 0);
    check("mid_idle", busy[0], 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    Start = 1'b0;
    load(16'h2000, 16'h1000, 16'h0000);
    @(negedge Clk);
    check_idle_outputs("reset");
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("idle");

    run_pass("pos", 1'b0);
    load(16'h2000, 16'hF000, 16'h0000);
    run_pass("neg", 1'b0);
    load(16'h2000, 16'h1C00, 16'h2000);
    run_pass("sat", 1'b0);
    load_random();
    run_pass("rand", 1'b0);
    load(16'h2000, 16'h1000, 16'h0000);
    run_pass("poke", 1'b1);
    reset_mid_pass();
    run_pass("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
